// File: rtl/cache_pkg.sv
// Shared constants for the two-way write-through data cache: state codes,
// address geometry and default parameters.
package cache_pkg;

   localparam int unsigned DEFAULT_SETS      = 64;
   localparam int unsigned DEFAULT_DATA_BASE = 1024;
   localparam int unsigned WA_W              = 17;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE      = 2'd0;
   localparam state_t S_READ_MISS = 2'd1;
   localparam state_t S_WRITE     = 2'd2;
   localparam state_t S_WDONE     = 2'd3;

   function automatic int unsigned idx_w(input int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned tag_w(input int unsigned sets);
      return WA_W - $clog2(sets);
   endfunction

endpackage

// File: rtl/cache_array.sv
// Two-way tag/data storage with per-set LRU bit; combinational lookup,
// synchronous fill, write-hit update, read-hit touch and flush.
module cache_array
   import cache_pkg::*;
#(
   parameter int unsigned SETS  = DEFAULT_SETS,
   parameter int unsigned IDX_W = idx_w(SETS),
   parameter int unsigned TAG_W = tag_w(SETS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic [31:0]      wdata_i,
   input  logic             fill_i,
   input  logic             update_i,
   input  logic             touch_i,
   output logic             hit_o,
   output logic [31:0]      rdata_o
);

   logic [SETS-1:0]  valid_q [2];
   logic [SETS-1:0]  lru_q;
   logic [TAG_W-1:0] tag_q   [2][SETS];
   logic [31:0]      data_q  [2][SETS];

   logic hit0, hit1, hit_way, victim;

   always_comb begin
      hit0    = valid_q[0][idx_i] && (tag_q[0][idx_i] == tag_i);
      hit1    = valid_q[1][idx_i] && (tag_q[1][idx_i] == tag_i);
      hit_o   = hit0 | hit1;
      hit_way = hit1;
      victim  = lru_q[idx_i];
      rdata_o = hit1 ? data_q[1][idx_i] : data_q[0][idx_i];
   end

   // LRU bit always ends up pointing away from the way just used.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         lru_q      <= '0;
      end else if (fill_i) begin
         valid_q[victim][idx_i] <= 1'b1;
         lru_q[idx_i]           <= ~victim;
      end else if ((update_i | touch_i) && hit_o) begin
         lru_q[idx_i] <= ~hit_way;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         if (fill_i) begin
            tag_q[victim][idx_i]  <= tag_i;
            data_q[victim][idx_i] <= wdata_i;
         end else if (update_i && hit_o) begin
            data_q[hit_way][idx_i] <= wdata_i;
         end
      end
   end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate cache front end: MEM-stage handshake on
// one side, SRAM controller wrEn/rdEn/ready handshake on the other.
module cache_controller
   import cache_pkg::*;
#(
   parameter int unsigned SETS      = DEFAULT_SETS,
   parameter int unsigned DATA_BASE = DEFAULT_DATA_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrEn,
   input  logic        rdEn,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   output logic        sramWrEn,
   output logic        sramRdEn,
   output logic [31:0] sramAddress,
   output logic [31:0] sramWriteData,
   input  logic [31:0] sramReadData,
   input  logic        sramReady
);

   localparam int unsigned IDX_W = idx_w(SETS);
   localparam int unsigned TAG_W = tag_w(SETS);

   state_t state_q, state_d;
   logic   issued_q, issued_d;

   logic [WA_W-1:0]  wa;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             hit, sram_done, fill, update, touch;
   logic [31:0]      array_wdata;

   assign wa  = WA_W'((address - 32'(DATA_BASE)) >> 2);
   assign idx = wa[IDX_W-1:0];
   assign tag = wa[WA_W-1:IDX_W];

   // issued_q masks the SRAM controller's idle-state ready during the entry cycle.
   assign sram_done   = sramReady & issued_q;
   assign array_wdata = (state_q == S_READ_MISS) ? sramReadData : writeData;

   always_comb begin
      state_d  = state_q;
      issued_d = 1'b0;
      ready    = 1'b0;
      fill     = 1'b0;
      update   = 1'b0;
      touch    = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready = ~(wrEn | rdEn) | (rdEn & ~wrEn & hit);
            if (wrEn)            state_d = S_WRITE;
            else if (rdEn & ~hit) state_d = S_READ_MISS;
            else if (rdEn)        touch   = 1'b1;
         end
         S_READ_MISS: begin
            issued_d = ~sram_done;
            if (sram_done) begin
               fill    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            issued_d = ~sram_done;
            if (sram_done) begin
               update  = 1'b1;
               state_d = S_WDONE;
            end
         end
         S_WDONE: begin
            ready   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         issued_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
      end
   end

   assign sramRdEn      = (state_q == S_READ_MISS);
   assign sramWrEn      = (state_q == S_WRITE);
   assign sramAddress   = address;
   assign sramWriteData = writeData;

   cache_array #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk_i    (clk),
      .rst_ni   (rst),
      .idx_i    (idx),
      .tag_i    (tag),
      .wdata_i  (array_wdata),
      .fill_i   (fill),
      .update_i (update),
      .touch_i  (touch),
      .hit_o    (hit),
      .rdata_o  (readData)
   );

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller against an MRU-ordered set model
// and a behavioural SRAM controller that holds ready high while idle.
module tb_cache_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wrEn = 1'b0, rdEn = 1'b0;
   logic [31:0] address = 32'd1024, writeData = '0;
   logic [31:0] readData, sramAddress, sramWriteData;
   logic        ready, sramWrEn, sramRdEn;
   logic [31:0] sramReadData = '0;
   logic        sramReady;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   cache_controller #(.SETS(64), .DATA_BASE(1024)) dut (
      .clk           (clk),
      .rst           (rst),
      .wrEn          (wrEn),
      .rdEn          (rdEn),
      .address       (address),
      .writeData     (writeData),
      .readData      (readData),
      .ready         (ready),
      .sramWrEn      (sramWrEn),
      .sramRdEn      (sramRdEn),
      .sramAddress   (sramAddress),
      .sramWriteData (sramWriteData),
      .sramReadData  (sramReadData),
      .sramReady     (sramReady)
   );

   function automatic logic [9:0] widx(input logic [31:0] a);
      logic [31:0] t;
      t = (a - 32'd1024) >> 2;
      return t[9:0];
   endfunction

   function automatic logic [31:0] pat(input int unsigned i);
      if (i == 0) return 32'hDEADBEEF;
      return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // ---------------- SRAM controller model ----------------
   logic [31:0] sram_mem [1024];
   logic        sram_init = 1'b0;
   logic        busy = 1'b0;
   int unsigned cnt = 0;
   int unsigned lat = 1;

   assign sramReady = !busy || (cnt == 0);

   always @(posedge clk) begin
      if (!sram_init) begin
         for (int i = 0; i < 1024; i++) sram_mem[i] <= pat(i);
         sram_init <= 1'b1;
      end
      if (!rst) begin
         busy <= 1'b0;
      end else if (!busy) begin
         if (sramRdEn || sramWrEn) begin
            busy         <= 1'b1;
            cnt          <= lat;
            sramReadData <= sram_mem[widx(sramAddress)];
         end
      end else if (cnt == 0) begin
         busy <= 1'b0;
         if (sramWrEn) sram_mem[widx(sramAddress)] <= sramWriteData;
      end else begin
         cnt <= cnt - 1;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_mem [1024];
   logic [31:0] lines [64][$];   // per set, most recently used first

   function automatic int setof(input logic [31:0] a);
      return int'(widx(a)) % 64;
   endfunction

   function automatic int find(input int s, input logic [31:0] a);
      for (int i = 0; i < lines[s].size(); i++)
         if (lines[s][i] == a) return i;
      return -1;
   endfunction

   task automatic model_touch(input int s, input int pos);
      logic [31:0] a;
      a = lines[s][pos];
      lines[s].delete(pos);
      lines[s].push_front(a);
   endtask

   task automatic model_fill(input int s, input logic [31:0] a);
      lines[s].push_front(a);
      if (lines[s].size() > 2) void'(lines[s].pop_back());
   endtask

   task automatic model_clear();
      for (int s = 0; s < 64; s++) lines[s].delete();
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // kind: 0 read, 1 write, 2 write+read asserted together
   task automatic access(input int kind, input logic [31:0] a, input logic [31:0] d);
      int s, pos, cyc;
      bit saw_rd, saw_wr, addr_bad, done;
      s        = setof(a);
      pos      = find(s, a);
      saw_rd   = 0;
      saw_wr   = 0;
      addr_bad = 0;
      done     = 0;
      lat      = $urandom_range(1, 3);
      @(posedge clk); #1;
      address   = a;
      writeData = d;
      wrEn      = (kind != 0);
      rdEn      = (kind != 1);
      @(negedge clk);
      if (kind == 0 && pos >= 0) begin
         check("hit_ready", 32'(ready), 32'd1);
         check("hit_data", readData, exp_mem[widx(a)]);
         check("hit_no_sram", 32'({sramRdEn, sramWrEn}), 32'd0);
         model_touch(s, pos);
      end else begin
         check("req_stall", 32'(ready), 32'd0);
         for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (sramRdEn) saw_rd = 1;
            if (sramWrEn) saw_wr = 1;
            if ((sramRdEn || sramWrEn) && sramAddress !== a) addr_bad = 1;
            if (sramWrEn && sramWriteData !== d) addr_bad = 1;
            if (ready) begin
               done = 1;
               break;
            end
         end
         check("latency", done ? 32'(cyc) : 32'd999, 32'(lat + 3));
         check("sram_rd_seen", 32'(saw_rd), 32'(kind == 0));
         check("sram_wr_seen", 32'(saw_wr), 32'(kind != 0));
         check("sram_addr_data", 32'(addr_bad), 32'd0);
         if (kind == 0) begin
            check("fill_data", readData, exp_mem[widx(a)]);
            model_fill(s, a);
         end else begin
            check("wdone_en_low", 32'({sramRdEn, sramWrEn}), 32'd0);
            exp_mem[widx(a)] = d;
            if (pos >= 0) model_touch(s, pos);
         end
      end
      @(posedge clk); #1;
      wrEn = 1'b0;
      rdEn = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int kind;
      for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);
      model_clear();

      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_sram_en", 32'({sramRdEn, sramWrEn}), 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_ready", 32'(ready), 32'd1);
         check("idle_no_sram", 32'({sramRdEn, sramWrEn}), 32'd0);
      end

      access(0, 32'd1024, '0);              // cold miss, DEADBEEF
      access(0, 32'd1024, '0);              // warm hit
      access(0, 32'd1280, '0);
      access(0, 32'd1024, '0);
      access(0, 32'd1536, '0);              // evicts 1280
      access(0, 32'd1024, '0);
      access(0, 32'd1280, '0);
      access(1, 32'd1024, 32'h12345678);    // write hit
      access(0, 32'd1024, '0);
      access(1, 32'd2048, 32'hCAFEF00D);    // write miss, no allocate
      access(0, 32'd2048, '0);
      access(2, 32'd1024, 32'h0BADF00D);    // simultaneous requests
      access(0, 32'd1024, '0);

      // reset in the middle of a fill
      @(posedge clk); #1;
      address = 32'd3072;
      rdEn    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midmiss_rd_en", 32'(sramRdEn), 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      rst  = 1'b1;
      rdEn = 1'b0;
      @(negedge clk);
      check("reset_rd_drop", 32'(sramRdEn), 32'd0);
      check("reset_ready", 32'(ready), 32'd1);
      model_clear();
      access(0, 32'd1024, '0);
      access(0, 32'd3072, '0);

      for (int n = 0; n < 300; n++) begin
         a    = 32'd1024 + 32'(4 * ($urandom_range(0, 3) * 64 + $urandom_range(0, 3)));
         kind = $urandom_range(0, 9);
         kind = (kind < 6) ? 0 : (kind < 9) ? 1 : 2;
         access(kind, a, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
